// File: rtl/sv_timer_pkg.sv
// Shared register offsets, CTRL bit positions and prescaler sizing for the
// Supervision system timer / IRQ block.
package sv_timer_pkg;

    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_MASK   = 4'h9;

    localparam int unsigned CTRL_RUN    = 0;
    localparam int unsigned CTRL_PSEL   = 1;
    localparam int unsigned CTRL_RELOAD = 2;

    localparam int unsigned PRE_SHORT_DEF = 256;
    localparam int unsigned PRE_LONG_DEF  = 16384;
    localparam int unsigned PRE_W         = $clog2(PRE_LONG_DEF);

    // CTRL readback image; bits [7:3] are always zero.
    function automatic logic [7:0] ctrl_byte(input logic run, input logic psel, input logic reload);
        logic [7:0] b;
        b              = '0;
        b[CTRL_RUN]    = run;
        b[CTRL_PSEL]   = psel;
        b[CTRL_RELOAD] = reload;
        return b;
    endfunction

endpackage

// File: rtl/sv_timer_irq_if.sv
// CPU-side register bus of the timer/IRQ block: select, write strobe,
// offset, data in both directions and the level IRQ back to the CPU.
interface sv_timer_irq_if;

    logic       cs;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       irq;

    modport master (
        output cs, we, addr, din,
        input  dout, irq
    );

    modport slave (
        input  cs, we, addr, din,
        output dout, irq
    );

endinterface

// File: rtl/sv_timer_irq_chan.sv
// One timer channel: prescaler, 8-bit down-counter, RUN/PSEL/RELOAD control
// and a single-cycle expiry pulse toward the STATUS register.
module sv_timer_chan
    import sv_timer_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned PRE_SHORT = PRE_SHORT_DEF,
    parameter int unsigned PRE_LONG  = PRE_LONG_DEF,
    parameter int unsigned PW        = PRE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_we,
    input  logic             ctrl_we,
    input  logic [7:0]       din,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       ctrl,
    output logic             expire
);

    localparam logic [PW-1:0] PRE_S = PW'(PRE_SHORT - 1);
    localparam logic [PW-1:0] PRE_L = PW'(PRE_LONG - 1);

    logic [PW-1:0]    pre, pre_nxt, pre_top;
    logic [CNT_W-1:0] count_nxt, reload_val, reload_val_nxt, load_val;
    logic             run, run_nxt, psel, psel_nxt, reload, reload_nxt;

    assign pre_top  = psel ? PRE_L : PRE_S;
    assign load_val = CNT_W'(din);
    assign ctrl     = ctrl_byte(run, psel, reload);

    // A CNT write overrides a coinciding tick, so only the write can expire.
    assign expire = cnt_we ? (load_val == '0)
                           : (run && pre == '0 && count == CNT_W'(1));

    always_comb begin
        pre_nxt        = pre;
        count_nxt      = count;
        reload_val_nxt = reload_val;
        run_nxt        = run;
        psel_nxt       = psel;
        reload_nxt     = reload;
        if (cnt_we) begin
            count_nxt      = load_val;
            reload_val_nxt = load_val;
            pre_nxt        = pre_top;
            run_nxt        = (load_val != '0);
        end else if (run) begin
            if (count == '0) begin
                run_nxt = 1'b0;
            end else if (pre == '0) begin
                pre_nxt = pre_top;
                if (count == CNT_W'(1)) begin
                    count_nxt = reload ? reload_val : '0;
                    run_nxt   = reload;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end else begin
                pre_nxt = pre - PW'(1);
            end
        end
        // RUN cannot be set while there is nothing left to count.
        if (ctrl_we) begin
            psel_nxt   = din[CTRL_PSEL];
            reload_nxt = din[CTRL_RELOAD];
            run_nxt    = din[CTRL_RUN] && (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre        <= '0;
            count      <= '0;
            reload_val <= '0;
            run        <= 1'b0;
            psel       <= 1'b0;
            reload     <= 1'b0;
        end else begin
            pre        <= pre_nxt;
            count      <= count_nxt;
            reload_val <= reload_val_nxt;
            run        <= run_nxt;
            psel       <= psel_nxt;
            reload     <= reload_nxt;
        end
    end

endmodule

// File: rtl/sv_timer_irq.sv
// Multi-channel system timer and IRQ controller: register decode, W1C STATUS,
// MASK, registered read port and the masked-OR IRQ line.
module sv_timer_irq
    import sv_timer_pkg::*;
#(
    parameter int unsigned NUM_TIMERS  = 2,
    parameter int unsigned NUM_EXT_IRQ = 1,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned PRE_SHORT   = PRE_SHORT_DEF,
    parameter int unsigned PRE_LONG    = PRE_LONG_DEF
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    sv_timer_irq_if.slave          bus,
    input  logic [NUM_EXT_IRQ-1:0] ext_irq
);

    localparam int unsigned NSRC = NUM_TIMERS + NUM_EXT_IRQ;
    localparam int unsigned PW   = (PRE_LONG > PRE_SHORT) ? $clog2(PRE_LONG) : $clog2(PRE_SHORT);
    localparam logic [7:0]  SRC_MASK = 8'((16'd1 << NSRC) - 16'd1);

    logic [NUM_TIMERS-1:0] cnt_we, ctrl_we, expire;
    logic [CNT_W-1:0]      count_ch [NUM_TIMERS];
    logic [7:0]            ctrl_ch  [NUM_TIMERS];
    logic [7:0]            status, status_nxt, mask, set_bits, clr_bits, rdata, dout_r;
    logic                  wr, rd, irq_r;

    assign wr = bus.cs && bus.we;
    assign rd = bus.cs && !bus.we;

    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
        assign cnt_we[g]  = wr && (bus.addr == 4'(2 * g));
        assign ctrl_we[g] = wr && (bus.addr == 4'(2 * g + 1));

        sv_timer_chan #(
            .CNT_W     (CNT_W),
            .PRE_SHORT (PRE_SHORT),
            .PRE_LONG  (PRE_LONG),
            .PW        (PW)
        ) u_chan (
            .clk     (clk_sys),
            .reset   (reset),
            .cnt_we  (cnt_we[g]),
            .ctrl_we (ctrl_we[g]),
            .din     (bus.din),
            .count   (count_ch[g]),
            .ctrl    (ctrl_ch[g]),
            .expire  (expire[g])
        );
    end

    always_comb begin
        set_bits                      = '0;
        set_bits[NUM_TIMERS-1:0]      = expire;
        set_bits[NSRC-1:NUM_TIMERS]   = ext_irq;
        clr_bits   = (wr && bus.addr == REG_STATUS) ? bus.din : '0;
        // Set is OR-ed after the clear so a coinciding event survives W1C.
        status_nxt = ((status & ~clr_bits) | set_bits) & SRC_MASK;
    end

    always_comb begin
        rdata = 8'hFF;
        if (bus.addr == REG_STATUS) begin
            rdata = status;
        end else if (bus.addr == REG_MASK) begin
            rdata = mask;
        end else begin
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                if (bus.addr == 4'(2 * i))     rdata = 8'(count_ch[i]);
                if (bus.addr == 4'(2 * i + 1)) rdata = ctrl_ch[i];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            status <= '0;
            mask   <= '0;
            irq_r  <= 1'b0;
            dout_r <= 8'hFF;
        end else begin
            status <= status_nxt;
            if (wr && bus.addr == REG_MASK) mask <= bus.din & SRC_MASK;
            irq_r <= |(status & mask);
            if (rd) dout_r <= rdata;
        end
    end

    assign bus.dout = dout_r;
    assign bus.irq  = irq_r;

endmodule

// File: tb/tb_sv_timer_irq.sv
// Directed bench for sv_timer_irq: reads go through an expected-value queue
// checked one cycle later; IRQ timing is measured in clk_sys edges.
module tb_sv_timer_irq;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [0:0]  ext_irq = '0;
    int unsigned checks  = 0;
    int unsigned errors  = 0;
    int unsigned cyc     = 0;
    int unsigned w0;
    logic        rd_seen = 1'b0;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    sv_timer_irq_if bus_if ();

    sv_timer_irq #(
        .NUM_TIMERS  (2),
        .NUM_EXT_IRQ (1),
        .CNT_W       (8),
        .PRE_SHORT   (256),
        .PRE_LONG    (16384)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_if),
        .ext_irq (ext_irq)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        cyc     <= cyc + 1;
        rd_seen <= bus_if.cs && !bus_if.we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read data lands on the edge that samples the read; compare it half a cycle later.
    always @(negedge clk_sys) begin
        if (rd_seen) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL rd_unexpected: observed %0h expected no read", bus_if.dout);
            end
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                string      t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                assert (bus_if.dout === e) else begin
                    errors++;
                    $error("FAIL %s: observed %0h expected %0h", t, bus_if.dout, e);
                end
            end
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.din = d;
        @(negedge clk_sys);
        bus_if.cs = 1'b0; bus_if.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [7:0] e, input string tag);
        @(negedge clk_sys);
        bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk_sys);
        bus_if.cs = 1'b0;
    endtask

    task automatic wait_irq(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!bus_if.irq && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.din = '0;

        // 1. reset state and full map readback
        idle(4);
        reset = 1'b0;
        idle(1);
        check("rst_dout", bus_if.dout, 8'hFF);
        check("rst_irq", bus_if.irq, 1'b0);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] e;
            e = (a < 4 || a == 8 || a == 9) ? 8'h00 : 8'hFF;
            bus_rd(4'(a), e, $sformatf("rst_rd_%0h", a));
        end

        // 2. one-shot timer 0, N=3, short prescale
        bus_wr(4'h9, 8'h01);
        bus_wr(4'h0, 8'h03);
        w0 = cyc;
        wait_irq(2000);
        check("t0_irq_delay", cyc - w0, 3 * 256 + 1);
        bus_rd(4'h8, 8'h01, "t0_status");
        bus_rd(4'h0, 8'h00, "t0_cnt_after");
        bus_rd(4'h1, 8'h00, "t0_ctrl_after");
        bus_wr(4'h8, 8'h01);
        idle(2);
        check("t0_irq_clr", bus_if.irq, 1'b0);

        // 3. auto-reload timer 1, N=2, long prescale
        bus_wr(4'h3, 8'h07);
        bus_rd(4'h3, 8'h06, "t1_ctrl_run_ignored");
        bus_wr(4'h9, 8'h02);
        bus_wr(4'h2, 8'h02);
        w0 = cyc;
        bus_rd(4'h3, 8'h07, "t1_ctrl_running");
        wait_irq(40000);
        check("t1_irq_delay1", cyc - w0, 2 * 16384 + 1);
        bus_rd(4'h2, 8'h02, "t1_cnt_reload1");
        bus_wr(4'h8, 8'h02);
        idle(2);
        check("t1_irq_clr", bus_if.irq, 1'b0);
        wait_irq(40000);
        check("t1_irq_delay2", cyc - w0, 4 * 16384 + 1);
        bus_rd(4'h2, 8'h02, "t1_cnt_reload2");
        bus_wr(4'h3, 8'h00);
        bus_wr(4'h8, 8'h02);
        bus_rd(4'h3, 8'h00, "t1_ctrl_stopped");

        // 4. CNT_0=0 expires immediately
        bus_wr(4'h9, 8'h01);
        bus_wr(4'h0, 8'h00);
        check("z_irq_lag", bus_if.irq, 1'b0);
        idle(1);
        check("z_irq_set", bus_if.irq, 1'b1);
        bus_rd(4'h8, 8'h01, "z_status");
        bus_rd(4'h1, 8'h00, "z_ctrl");
        bus_wr(4'h8, 8'h01);
        idle(1);
        check("z_irq_drop", bus_if.irq, 1'b0);

        // 5. ext pulse coinciding with a full W1C write
        bus_wr(4'h9, 8'h04);
        @(negedge clk_sys);
        bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = 4'h8; bus_if.din = 8'hFF;
        ext_irq = 1'b1;
        @(negedge clk_sys);
        bus_if.cs = 1'b0; bus_if.we = 1'b0;
        ext_irq = 1'b0;
        bus_rd(4'h8, 8'h04, "ext_set_wins");
        check("ext_irq", bus_if.irq, 1'b1);
        bus_wr(4'h8, 8'h04);
        bus_rd(4'h8, 8'h00, "ext_cleared");

        // 6. reset while counting with STATUS pending
        bus_wr(4'h9, 8'h03);
        bus_wr(4'h0, 8'h00);
        bus_wr(4'h2, 8'h00);
        bus_wr(4'h0, 8'h05);
        idle(100);
        bus_rd(4'h8, 8'h03, "pre_rst_status");
        bus_rd(4'h0, 8'h05, "pre_rst_cnt");
        bus_rd(4'h1, 8'h01, "pre_rst_ctrl");
        check("pre_rst_irq", bus_if.irq, 1'b1);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        check("mid_rst_irq", bus_if.irq, 1'b0);
        check("mid_rst_dout", bus_if.dout, 8'hFF);
        reset = 1'b0;
        bus_rd(4'h0, 8'h00, "post_rst_cnt0");
        bus_rd(4'h1, 8'h00, "post_rst_ctrl0");
        bus_rd(4'h8, 8'h00, "post_rst_status");
        bus_rd(4'h9, 8'h00, "post_rst_mask");
        idle(5 * 256 + 200);
        bus_rd(4'h8, 8'h00, "post_rst_no_expiry");
        bus_rd(4'h0, 8'h00, "post_rst_cnt_frozen");
        check("post_rst_irq", bus_if.irq, 1'b0);

        idle(3);
        check("rd_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
